// File: rtl/ram_burst_master.sv
// ram_burst_master: burst command controller driving a single-port RAM, with a write stream in and a 2-entry read buffer out.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [AW-1:0]         cmd_addr_i,
  input  logic [LW-1:0]         cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] wr_mask_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [DATA_WIDTH-1:0] ram_wmask_o,
  output logic                  ram_wp_o,
  output logic                  ram_test_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d, addr_inc;
  logic [LW-1:0]         rem_q, rem_d, len_c;
  logic                  if_q, if_d, if_last_q, if_last_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [1:0]            buf_last_q, cnt_q;
  logic                  head_q, wr_idx;
  logic                  accept, wbeat, issue, pop, last_beat;

  assign accept    = cmd_valid_i && state_q == S_IDLE;
  assign len_c     = cmd_len_i > LEN_MAX ? LEN_MAX : cmd_len_i;
  assign wbeat     = state_q == S_WRITE && wr_valid_i;
  assign pop       = rd_valid_o && rd_ready_i;
  // Counting the same-cycle pop lets a read issue every cycle while the consumer keeps up.
  assign issue     = state_q == S_READ && (3'(cnt_q) + 3'(if_q) - 3'(pop)) < 3'd2;
  assign last_beat = rem_q == LW'(1);
  assign addr_inc  = addr_q == ADDR_MAX ? '0 : addr_q + AW'(1);
  assign wr_idx    = head_q ^ cnt_q[0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    if_d      = issue;
    if_last_d = issue && last_beat;
    if (accept) begin
      addr_d  = cmd_addr_i;
      rem_d   = len_c;
      state_d = len_c == '0 ? S_DONE : cmd_write_i ? S_WRITE : S_READ;
    end
    if (wbeat || issue) begin
      addr_d = addr_inc;
      rem_d  = rem_q - LW'(1);
    end
    if ((wbeat || issue) && last_beat) state_d = wbeat ? S_DONE : S_DRAIN;
    if (state_q == S_DRAIN && cnt_q == '0 && !if_q) state_d = S_DONE;
    if (state_q == S_DONE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      if_q      <= 1'b0;
      if_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      if_q      <= if_d;
      if_last_q <= if_last_d;
    end
  end

  // RAM data lands one cycle after issue; the in-flight flag marks that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      buf_last_q <= '0;
      head_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (if_q) begin
        buf_q[wr_idx]      <= ram_rdata_i;
        buf_last_q[wr_idx] <= if_last_q;
      end
      if (pop) head_q <= ~head_q;
      cnt_q <= cnt_q + 2'(if_q) - 2'(pop);
    end
  end

  assign cmd_ready_o = state_q == S_IDLE;
  assign wr_ready_o  = state_q == S_WRITE;
  assign busy_o      = state_q != S_IDLE;
  assign done_o      = state_q == S_DONE;
  assign rd_valid_o  = cnt_q != '0;
  assign rd_data_o   = buf_q[head_q];
  assign rd_last_o   = rd_valid_o && buf_last_q[head_q];
  assign ram_en_o    = wbeat || issue;
  assign ram_we_o    = wbeat;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wbeat ? wr_data_i : '0;
  assign ram_wmask_o = wbeat ? wr_mask_i : '0;
  assign ram_wp_o    = 1'b0;
  assign ram_test_o  = 1'b0;
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed checks of write, read, stall, wrap, zero-length, clamp and reset-abort bursts.
module tb_ram_burst_master;
  localparam int DW = 8, DEPTH = 16, AW = 4, LW = 5;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data, wr_mask;
  logic rd_valid, rd_ready, rd_last, done, busy;
  logic [DW-1:0] rd_data;
  logic ram_en, ram_we, ram_wp, ram_test;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_wmask, ram_rdata;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wq [32];
  logic [DW-1:0] wmask;
  int wr_ptr = 0, wr_base = 0;

  logic [AW-1:0] wlog [$];
  logic [DW-1:0] rlog [$];
  logic llog [$];
  int rcyc [$];
  int iss = 0, dn = 0, dcyc = 0, acyc = 0, cyc = 0, wpbad = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_o(done), .busy_o(busy),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
    .ram_wp_o(ram_wp), .ram_test_o(ram_test), .ram_rdata_i(ram_rdata)
  );

  assign wr_data = wq[(wr_ptr - wr_base) & 31];
  assign wr_mask = wmask;

  // Behavioural single-port RAM with registered read and bit-masked write.
  always @(posedge clk) begin
    if (wr_valid && wr_ready) wr_ptr <= wr_ptr + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (ram_en && ram_we) wlog.push_back(ram_addr);
    if (ram_en && !ram_we) iss++;
    if (rd_valid && rd_ready) begin
      rlog.push_back(rd_data);
      llog.push_back(rd_last);
      rcyc.push_back(cyc);
    end
    if (done) begin dn++; dcyc = cyc; end
    if (cmd_valid && cmd_ready) acyc = cyc;
    if (ram_wp || ram_test) wpbad++;
  end

  task automatic clear_logs();
    wlog.delete(); rlog.delete(); llog.delete(); rcyc.delete();
    iss = 0; dn = 0;
    wr_base = wr_ptr;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    @(posedge clk); #1;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (!cmd_ready) begin bad++; $display("FAIL cmd_accept got=%0b exp=1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (dn == 0 && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (dn == 0) begin bad++; $display("FAIL %s timeout got=0 exp=done", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; rd_ready = 0; wmask = 8'hFF;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({rd_valid, rd_last, done, busy, ram_en, ram_we} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=000000", {rd_valid, rd_last, done, busy, ram_en, ram_we});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    clear_logs();
    for (int i = 0; i < 4; i++) wq[i] = 8'hA0 + 8'(i);
    wmask = 8'hFF; wr_valid = 1'b1;
    send_cmd(1'b1, 4'd3, 5'd4);
    wait_done("t1_done");
    @(posedge clk); #1; wr_valid = 1'b0;
    total++;
    if (wlog.size() !== 4) begin bad++; $display("FAIL t1_beats got=%0d exp=4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[i] !== 4'(3 + i)) begin bad++; $display("FAIL t1_addr%0d got=%0d exp=%0d", i, wlog[i], 3 + i); end
      total++;
      if (mem[3 + i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL t1_mem%0d got=%h exp=%h", i, mem[3 + i], 8'hA0 + 8'(i)); end
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL t1_done_cnt got=%0d exp=1", dn); end
  endtask

  task automatic test_read();
    clear_logs();
    rd_ready = 1'b1;
    send_cmd(1'b0, 4'd3, 5'd4);
    wait_done("t2_done");
    repeat (2) @(posedge clk); #1;
    total++;
    if (rlog.size() !== 4) begin bad++; $display("FAIL t2_beats got=%0d exp=4", rlog.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rlog[i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL t2_data%0d got=%h exp=%h", i, rlog[i], 8'hA0 + 8'(i)); end
      total++;
      if (llog[i] !== (i == 3)) begin bad++; $display("FAIL t2_last%0d got=%0b exp=%0b", i, llog[i], i == 3); end
      total++;
      if (rcyc[i] !== acyc + 3 + i) begin bad++; $display("FAIL t2_cycle%0d got=%0d exp=%0d", i, rcyc[i] - acyc, 3 + i); end
    end
    total++;
    if (dn !== 1 || dcyc <= rcyc[3]) begin bad++; $display("FAIL t2_done got=%0d@%0d exp=1 after %0d", dn, dcyc, rcyc[3]); end
  endtask

  task automatic test_stall();
    clear_logs();
    rd_ready = 1'b0;
    send_cmd(1'b0, 4'd3, 5'd4);
    repeat (5) @(negedge clk);
    total++;
    if (iss !== 2) begin bad++; $display("FAIL t3_issues got=%0d exp=2", iss); end
    @(posedge clk); #1; rd_ready = 1'b1;
    wait_done("t3_done");
    total++;
    if (rlog.size() !== 4) begin bad++; $display("FAIL t3_beats got=%0d exp=4", rlog.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rlog[i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL t3_data%0d got=%h exp=%h", i, rlog[i], 8'hA0 + 8'(i)); end
    end
    total++;
    if (llog[3] !== 1'b1) begin bad++; $display("FAIL t3_last got=%0b exp=1", llog[3]); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    clear_logs();
    for (int i = 0; i < 4; i++) wq[i] = 8'h00;
    wmask = 8'hFF; wr_valid = 1'b1;
    send_cmd(1'b1, 4'd14, 5'd4);
    wait_done("t4_done");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[i] !== exp_a[i]) begin bad++; $display("FAIL t4_addr%0d got=%0d exp=%0d", i, wlog[i], exp_a[i]); end
    end
    clear_logs();
    wq[0] = 8'hFF; wmask = 8'h0F;
    send_cmd(1'b1, 4'd15, 5'd1);
    wait_done("t4_mask_done");
    @(posedge clk); #1; wr_valid = 1'b0;
    total++;
    if (mem[15] !== 8'h0F) begin bad++; $display("FAIL t4_mask_mem got=%h exp=0f", mem[15]); end
    clear_logs();
    rd_ready = 1'b1;
    send_cmd(1'b0, 4'd15, 5'd1);
    wait_done("t4_read_done");
    total++;
    if (rlog.size() !== 1 || rlog[0] !== 8'h0F || llog[0] !== 1'b1) begin
      bad++; $display("FAIL t4_mask_read got=%h last=%0b n=%0d exp=0f last=1 n=1", rlog[0], llog[0], rlog.size());
    end
  endtask

  task automatic test_zero();
    clear_logs();
    send_cmd(1'b0, 4'd5, 5'd0);
    wait_done("t5_done");
    total++;
    if (dcyc !== acyc + 1) begin bad++; $display("FAIL t5_done_lat got=%0d exp=1", dcyc - acyc); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL t5_ready got=%0b exp=1", cmd_ready); end
    @(posedge clk); #1;
    total++;
    if (iss !== 0 || wlog.size() !== 0 || dn !== 1) begin
      bad++; $display("FAIL t5_noaccess got=iss%0d wr%0d done%0d exp=iss0 wr0 done1", iss, wlog.size(), dn);
    end
  endtask

  task automatic test_clamp();
    clear_logs();
    for (int i = 0; i < 16; i++) wq[i] = 8'h10 + 8'(i);
    wmask = 8'hFF; wr_valid = 1'b1;
    send_cmd(1'b1, 4'd0, 5'd31);
    wait_done("clamp_done");
    @(posedge clk); #1; wr_valid = 1'b0;
    total++;
    if (wlog.size() !== 16) begin bad++; $display("FAIL clamp_beats got=%0d exp=16", wlog.size()); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mem[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL clamp_mem%0d got=%h exp=%h", i, mem[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    rd_ready = 1'b0;
    send_cmd(1'b0, 4'd0, 5'd8);
    repeat (2) @(posedge clk); #1;
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL t6_pre_valid got=%0b exp=1", rd_valid); end
    rst = 1'b1; #1;
    total++;
    if ({rd_valid, ram_en, busy} !== 3'b000) begin bad++; $display("FAIL t6_abort got=%b exp=000", {rd_valid, ram_en, busy}); end
    @(posedge clk); #1; rst = 1'b0;
    iss = 0;
    repeat (6) @(posedge clk); #1;
    total++;
    if (dn !== 0 || iss !== 0) begin bad++; $display("FAIL t6_quiet got=done%0d iss%0d exp=done0 iss0", dn, iss); end
    clear_logs();
    rd_ready = 1'b1;
    send_cmd(1'b0, 4'd3, 5'd4);
    wait_done("t6_rerun_done");
    total++;
    if (rlog.size() !== 4) begin bad++; $display("FAIL t6_beats got=%0d exp=4", rlog.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rlog[i] !== 8'h13 + 8'(i) || llog[i] !== (i == 3)) begin
        bad++; $display("FAIL t6_data%0d got=%h/%0b exp=%h/%0b", i, rlog[i], llog[i], 8'h13 + 8'(i), i == 3);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) wq[i] = '0;
    ram_rdata = '0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_wrap();
    test_zero();
    test_clamp();
    test_reset_mid();
    total++;
    if (wpbad !== 0) begin bad++; $display("FAIL wp_test_pins got=%0d exp=0", wpbad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
